// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the vector streamer.
//   DATA_W        : element width in bits (signed 8-bit elements)
//   DEPTH_DEFAULT : default number of elements per vector memory
//   state_t       : sequencer states of vec_streamer
// -----------------------------------------------------------------------------
package vec_pkg;

    localparam int DATA_W        = 8;
    localparam int DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

endpackage

// File: rtl/vec_ram.sv
// -----------------------------------------------------------------------------
// vec_ram
// Single-write / single-read memory with a registered (1-cycle) read port.
// Contents have no reset, so they survive a controller reset.
// Ports:
//   clk        : clock, rising edge
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_addr  : read address, sampled every rising edge
//   o_rd_data  : data at i_rd_addr from the previous rising edge
// -----------------------------------------------------------------------------
module vec_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/vec_streamer.sv
// -----------------------------------------------------------------------------
// vec_streamer
// Holds two signed element vectors (A and B) written from a register block and,
// on a go request, streams N element pairs back-to-back to a dot-product engine,
// then waits for the engine's completion flag.
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   wr_en/wr_sel        : element write strobe; wr_sel 0 = A, 1 = B
//   wr_addr/wr_data     : element index and signed value
//   len_in, go          : requested length N and single-cycle start request
//   accel_done          : completion flag from the engine (honoured in WAIT)
//   init_loading        : high from stream arm until return to IDLE
//   vector_valid        : element pair valid this cycle
//   vector_a_out/_b_out : element pair, forced to 0 when not valid
//   vector_len          : latched N
//   writes_done         : high after the last pair until accel_done
//   busy                : high in any state other than IDLE
//   done_pulse          : one-cycle completion strobe
//   len_err             : one-cycle strobe on a rejected go
//   wr_ignored          : sticky, write attempted while busy; cleared by accepted go
// -----------------------------------------------------------------------------
module vec_streamer
    import vec_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [31:0]       len_in,
    input  logic              go,
    input  logic              accel_done,
    output logic              init_loading,
    output logic              vector_valid,
    output logic [DATA_W-1:0] vector_a_out,
    output logic [DATA_W-1:0] vector_b_out,
    output logic [31:0]       vector_len,
    output logic              writes_done,
    output logic              busy,
    output logic              done_pulse,
    output logic              len_err,
    output logic              wr_ignored
);

    state_t r_state;
    state_t w_next_state;

    // One extra bit so that N = DEPTH can count up to DEPTH without wrapping.
    logic [ADDR_W:0]   r_addr;
    logic [31:0]       r_len;
    logic              r_vld_p1;
    logic              r_done_pulse;
    logic              r_len_err;
    logic              r_wr_ignored;

    logic              w_idle;
    logic              w_len_ok;
    logic              w_accept;
    logic              w_last;
    logic              w_wr_a;
    logic              w_wr_b;
    logic [DATA_W-1:0] w_a_q;
    logic [DATA_W-1:0] w_b_q;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_len_ok = (len_in != 32'd0) && (len_in <= 32'(DEPTH));
    assign w_accept = w_idle && go && w_len_ok;
    assign w_last   = ({{(31-ADDR_W){1'b0}}, r_addr} == (r_len - 32'd1));

    // Writes land only while IDLE; a write in the same cycle as go still
    // commits before the first read two edges later.
    assign w_wr_a = wr_en && !wr_sel && w_idle;
    assign w_wr_b = wr_en &&  wr_sel && w_idle;

    vec_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_a (
        .clk       (clk),
        .i_wr_en   (w_wr_a),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_addr[ADDR_W-1:0]),
        .o_rd_data (w_a_q)
    );

    vec_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_b (
        .clk       (clk),
        .i_wr_en   (w_wr_b),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_addr[ADDR_W-1:0]),
        .o_rd_data (w_b_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept)   w_next_state = ST_ARM;
            ST_ARM:                    w_next_state = ST_STREAM;
            ST_STREAM: if (w_last)     w_next_state = ST_DRAIN;
            ST_DRAIN:                  w_next_state = ST_WAIT;
            ST_WAIT:   if (accel_done) w_next_state = ST_IDLE;
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    // Read address: cleared in ARM, advanced once per STREAM cycle.
    always_ff @(posedge clk) begin
        if (r_state == ST_ARM) begin
            r_addr <= '0;
        end else if (r_state == ST_STREAM) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Stage p1: RAM read data and its valid flag leave together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_len        <= '0;
            r_vld_p1     <= 1'b0;
            r_done_pulse <= 1'b0;
            r_len_err    <= 1'b0;
            r_wr_ignored <= 1'b0;
        end else begin
            r_vld_p1     <= (r_state == ST_STREAM);
            r_done_pulse <= (r_state == ST_WAIT) && accel_done;
            r_len_err    <= w_idle && go && !w_len_ok;
            if (w_accept) begin
                r_len        <= len_in;
                r_wr_ignored <= 1'b0;
            end else if (wr_en && !w_idle) begin
                r_wr_ignored <= 1'b1;
            end
        end
    end

    assign vector_valid = r_vld_p1;
    assign vector_a_out = r_vld_p1 ? w_a_q : '0;
    assign vector_b_out = r_vld_p1 ? w_b_q : '0;
    assign vector_len   = r_len;
    assign busy         = !w_idle;
    assign init_loading = !w_idle;
    assign writes_done  = (r_state == ST_WAIT);
    assign done_pulse   = r_done_pulse;
    assign len_err      = r_len_err;
    assign wr_ignored   = r_wr_ignored;

endmodule

// File: tb/tb_vec_streamer.sv
module tb_vec_streamer;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [31:0]       len_in;
    logic              go;
    logic              accel_done;
    logic              init_loading;
    logic              vector_valid;
    logic [7:0]        vector_a_out;
    logic [7:0]        vector_b_out;
    logic [31:0]       vector_len;
    logic              writes_done;
    logic              busy;
    logic              done_pulse;
    logic              len_err;
    logic              wr_ignored;

    int tests = 0;
    int fails = 0;

    // Reference contents of the two vector memories.
    logic [7:0] mA [DEPTH];
    logic [7:0] mB [DEPTH];

    vec_streamer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .len_in       (len_in),
        .go           (go),
        .accel_done   (accel_done),
        .init_loading (init_loading),
        .vector_valid (vector_valid),
        .vector_a_out (vector_a_out),
        .vector_b_out (vector_b_out),
        .vector_len   (vector_len),
        .writes_done  (writes_done),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .len_err      (len_err),
        .wr_ignored   (wr_ignored)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({init_loading, vector_valid, vector_a_out, vector_b_out, vector_len,
                    writes_done, busy, done_pulse, len_err, wr_ignored});
    endfunction

    task automatic wr(input bit sel, input int addr, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = ADDR_W'(addr);
        wr_data = d;
        tick;
        wr_en = 1'b0;
        if (sel) mB[addr] = d;
        else     mA[addr] = d;
    endtask

    task automatic fill_rand(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wr(1'b0, i, 8'($urandom));
            wr(1'b1, i, 8'($urandom));
        end
    endtask

    // Full transaction: go with length n, expect n contiguous pairs taken from
    // the reference memories, then WAIT for waitc cycles, then completion.
    // inj: drive a dropped write, a stray accel_done and a stray go mid-stream.
    // wgo: write B[0] in the same cycle as go; the new value must be streamed.
    task automatic run_vector(input int n, input int waitc, input bit inj, input bit wgo);
        logic [7:0] d;
        d      = 8'($urandom);
        go     = 1'b1;
        len_in = 32'(n);
        if (wgo) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b1;
            wr_addr = '0;
            wr_data = d;
        end
        tick;
        go    = 1'b0;
        wr_en = 1'b0;
        if (wgo) mB[0] = d;
        chk("e0_init_loading", 64'(init_loading), 64'd1);
        chk("e0_busy", 64'(busy), 64'd1);
        chk("e0_vector_len", 64'(vector_len), 64'(n));
        chk("e0_wr_ignored", 64'(wr_ignored), 64'd0);
        chk("e0_valid", 64'(vector_valid), 64'd0);
        tick;
        chk("e1_valid_ab", 64'({vector_valid, vector_a_out, vector_b_out}), 64'd0);
        for (int k = 0; k < n; k++) begin
            tick;
            wr_en      = 1'b0;
            accel_done = 1'b0;
            go         = 1'b0;
            chk($sformatf("pair%0d", k), 64'({vector_valid, vector_a_out, vector_b_out}),
                64'({1'b1, mA[k], mB[k]}));
            chk("stream_writes_done", 64'(writes_done), 64'd0);
            if (inj) begin
                if (k == 0) begin
                    wr_en   = 1'b1;
                    wr_sel  = 1'b0;
                    wr_addr = '0;
                    wr_data = 8'd99;
                end
                if (k == 1) accel_done = 1'b1;
                if (k == 2) begin
                    go     = 1'b1;
                    len_in = 32'(n + 1);
                end
            end
        end
        tick;
        chk("drain_valid_ab", 64'({vector_valid, vector_a_out, vector_b_out}), 64'd0);
        chk("drain_writes_done", 64'(writes_done), 64'd1);
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_vector_len", 64'(vector_len), 64'(n));
        chk("drain_wr_ignored", 64'(wr_ignored), 64'(inj));
        for (int w = 0; w < waitc; w++) begin
            tick;
            chk("wait_hold", 64'({writes_done, init_loading, done_pulse, vector_valid}), 64'b1100);
        end
        accel_done = 1'b1;
        tick;
        accel_done = 1'b0;
        chk("done_pulse", 64'(done_pulse), 64'd1);
        chk("done_status", 64'({busy, writes_done, init_loading}), 64'd0);
        tick;
        chk("done_pulse_once", 64'(done_pulse), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic bad_go(input logic [31:0] n, input logic exp_wi);
        go     = 1'b1;
        len_in = n;
        tick;
        go = 1'b0;
        chk("len_err_pulse", 64'(len_err), 64'd1);
        chk("len_err_busy", 64'({busy, init_loading, vector_valid}), 64'd0);
        chk("len_err_wr_ignored_kept", 64'(wr_ignored), 64'(exp_wi));
        tick;
        chk("len_err_once", 64'(len_err), 64'd0);
        tick;
        chk("len_err_no_stream", 64'({busy, vector_valid}), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        wr_en      = 1'b0;
        wr_sel     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        len_in     = '0;
        go         = 1'b0;
        accel_done = 1'b0;
        tick;
        tick;
        chk("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;
        tick;
        chk("idle_outputs", all_outs(), 64'd0);

        // Directed example: A={1,2,3,4}, B={5,6,7,8}, N=4, 10 wait cycles.
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, i, 8'(i + 1));
            wr(1'b1, i, 8'(i + 5));
        end
        run_vector(4, 10, 1'b0, 1'b0);

        // Random data with mid-stream disturbances that must be ignored.
        fill_rand(16);
        run_vector(int'($urandom_range(16, 4)), int'($urandom_range(6, 0)), 1'b1, 1'b0);

        // Rejected lengths; wr_ignored from the previous run must persist.
        bad_go(32'd0, 1'b1);
        bad_go(32'(DEPTH + 1), 1'b1);

        // Full-depth vector with extreme values: exactly DEPTH pairs, no wrap.
        for (int i = 0; i < DEPTH; i++) begin
            wr(1'b0, i, 8'h80);
            wr(1'b1, i, 8'h7f);
        end
        run_vector(DEPTH, 2, 1'b0, 1'b0);

        // Reset during pair 2 of an N=8 stream; memory must survive.
        fill_rand(8);
        go     = 1'b1;
        len_in = 32'd8;
        tick;
        go = 1'b0;
        tick;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("pre_reset_pair%0d", k),
                64'({vector_valid, vector_a_out, vector_b_out}), 64'({1'b1, mA[k], mB[k]}));
        end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_reset_outputs", all_outs(), 64'd0);
        tick;
        chk("post_reset_quiet", all_outs(), 64'd0);
        run_vector(8, 3, 1'b0, 1'b0);

        // Same-cycle write and go, then a couple of random lengths.
        fill_rand(32);
        run_vector(int'($urandom_range(32, 1)), 1, 1'b0, 1'b1);
        run_vector(1, 0, 1'b0, 1'b0);
        run_vector(int'($urandom_range(32, 4)), int'($urandom_range(5, 0)), 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
